uart_tx_buffered: RTL

Parametrised, FIFO-buffered UART transmitter: the next-generation TX path for the UART subsystem. It accepts words from the host side into an internal FIFO and serialises them onto `o_uart_tx` with configurable data width, parity and stop bits. Back-to-back frames go out with no idle gap. The existing `uart_rx` can loop it back for 8N1 checks.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_buffered.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX FSM encoding and a constant clog2.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      din_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok_c;
  logic             pop_ok_c;

  // Flags are sampled before the edge, so a pop never makes room for a same-edge push.
  assign push_ok_c = push_i & ~full_q;
  assign pop_ok_c  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter; frames leave back-to-back while words are queued.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_n,
  input  logic                       i_TX_DV,
  input  logic [DATA_BITS-1:0]       i_TX_Byte,
  output logic                       o_TX_Ready,
  output logic                       o_TX_Active,
  output logic                       o_uart_tx,
  output logic                       o_TX_Done,
  output logic                       o_Overflow,
  output logic [clog2(FIFO_DEPTH):0] o_FIFO_Count
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int unsigned CNT_W = clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = clog2(DATA_BITS);
  localparam int unsigned CW    = clog2(FIFO_DEPTH) + 1;

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 ovf_q;

  logic                 bit_end_c;
  logic                 fifo_push_c;
  logic                 fifo_pop_c;
  logic                 fifo_full_c;
  logic                 fifo_empty_c;
  logic [DATA_BITS-1:0] fifo_dout_c;
  logic [CW-1:0]        fifo_count_c;

  assign fifo_push_c = i_TX_DV & ~fifo_full_c;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_n_i (i_Rst_n),
    .push_i  (fifo_push_c),
    .pop_i   (fifo_pop_c),
    .din_i   (i_TX_Byte),
    .dout_o  (fifo_dout_c),
    .full_o  (fifo_full_c),
    .empty_o (fifo_empty_c),
    .count_o (fifo_count_c)
  );

  assign bit_end_c = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // State and datapath registers; serial outputs are registered from next-state values.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      active_q  <= active_d;
      done_q    <= done_d;
      ovf_q     <= i_TX_DV & fifo_full_c;
    end
  end

  // Next state, counters, shift register and parity accumulator.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    fifo_pop_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!fifo_empty_c) begin
          fifo_pop_c = 1'b1;
          shift_d    = fifo_dout_c;
          par_d      = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          par_d     = par_q ^ shift_q[0];
          shift_d   = shift_q >> 1;
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            if (!fifo_empty_c) begin
              fifo_pop_c = 1'b1;
              shift_d    = fifo_dout_c;
              par_d      = 1'b0;
              state_d    = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Line level, activity and end-of-frame pulse for the cycle after the edge.
  always_comb begin
    tx_d     = 1'b1;
    active_d = (state_d != ST_IDLE);
    done_d   = (state_d == ST_STOP) &&
               (bit_idx_d == IDX_W'(STOP_BITS - 1)) &&
               (clk_cnt_d == CNT_W'(CLKS_PER_BIT - 1));
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d ^ (PARITY == PAR_ODD);
      default:   tx_d = 1'b1;
    endcase
  end

  assign o_TX_Ready   = ~fifo_full_c;
  assign o_TX_Active  = active_q;
  assign o_uart_tx    = tx_q;
  assign o_TX_Done    = done_q;
  assign o_Overflow   = ovf_q;
  assign o_FIFO_Count = fifo_count_c;

endmodule
